// File: rtl/cnn_accel_pkg.sv
// Shared constants for the CNN accelerator scheduler.
// State encodings, bank-select indices and pipeline latency helper.
package cnn_accel_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SEL_IMG   = 0;
  localparam int SEL_COEF0 = 1;

  function automatic int pipe_lat(
    input int rd_lat,
    input int comp_lat
  );
    return rd_lat + comp_lat;
  endfunction

endpackage

// File: rtl/cnn_delay_line.sv
// N-stage shift register with async clear and sync flush.
// Carries valid/sof/address alongside the datapath latency.
module cnn_delay_line #(
  parameter int W = 1,
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] pipe [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) pipe[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[N-1];

endmodule

// File: rtl/cnn_accel_sched.sv
// Sequencer and memory-port arbiter for the CNN accelerator.
// Host loads in IDLE, raster scan in RUN, pipeline drain, done pulse.
module cnn_accel_sched
  import cnn_accel_pkg::*;
#(
  parameter int DWIDTH   = 32,
  parameter int HEIGHT   = 8,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int RD_LAT   = 1,
  parameter int COMP_LAT = 2,
  localparam int HW = $clog2(HEIGHT),
  localparam int WW = $clog2(WIDTH),
  localparam int SW = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              ld_req,
  input  logic [SW-1:0]     ld_sel,
  input  logic [HW-1:0]     ld_haddr,
  input  logic [WW-1:0]     ld_waddr,
  input  logic [DWIDTH-1:0] ld_data,
  output logic              ld_gnt,
  output logic [DEPTH:0]    mem_rw,
  output logic [HW-1:0]     mem_haddr,
  output logic [WW-1:0]     mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              comp_en,
  output logic              comp_sof,
  output logic              out_we_n,
  output logic [HW-1:0]     out_haddr,
  output logic [WW-1:0]     out_waddr
);

  localparam int PL = pipe_lat(RD_LAT, COMP_LAT);
  localparam int DW = $clog2(PL+1);

  logic [1:0]    state;
  logic [HW-1:0] hcnt;
  logic [WW-1:0] wcnt;
  logic [DW-1:0] dcnt;
  logic          start_pend;

  logic idle;
  logic go;
  logic issue;
  logic first;
  logic wlast;
  logic last;
  logic ld_ok;
  logic wr;
  logic out_vld;

  assign idle  = state == S_IDLE;
  assign issue = state == S_RUN;
  assign go    = idle & (start | start_pend) & ~ld_req & ~abort;
  assign wlast = wcnt == WW'(WIDTH-1);
  assign last  = wlast && (hcnt == HW'(HEIGHT-1));
  assign first = issue && (hcnt == '0) && (wcnt == '0);

  // Out-of-range selects are granted but dropped so the host never hangs
  assign ld_ok  = ld_sel <= SW'(DEPTH);
  assign ld_gnt = idle & ld_req;
  assign wr     = ld_gnt & ld_ok;

  assign busy = (state == S_RUN) | (state == S_DRAIN);
  assign done = state == S_DONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      wcnt       <= '0;
      dcnt       <= '0;
      start_pend <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      wcnt       <= '0;
      dcnt       <= '0;
      start_pend <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_RUN;
            start_pend <= 1'b0;
          end else if (start) begin
            start_pend <= 1'b1;
          end
        end
        S_RUN: begin
          if (last) begin
            state <= S_DRAIN;
            hcnt  <= '0;
            wcnt  <= '0;
          end else if (wlast) begin
            wcnt <= '0;
            hcnt <= hcnt + HW'(1);
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt == DW'(PL-1)) begin
            state <= S_DONE;
            dcnt  <= '0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rw    = '1;
    mem_haddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (issue) begin
      mem_haddr = hcnt;
      mem_waddr = wcnt;
    end else if (wr) begin
      for (int k = 0; k <= DEPTH; k++) begin
        if (ld_sel == SW'(k)) mem_rw[k] = 1'b0;
      end
      mem_haddr = ld_haddr;
      mem_waddr = ld_waddr;
      mem_wdata = ld_data;
    end
  end

  cnn_delay_line #(
    .W(2),
    .N(RD_LAT)
  ) u_rd_dl (
    .clk  (clk),
    .reset(reset),
    .flush(abort),
    .d    ({issue, first}),
    .q    ({comp_en, comp_sof})
  );

  cnn_delay_line #(
    .W(1 + HW + WW),
    .N(PL)
  ) u_out_dl (
    .clk  (clk),
    .reset(reset),
    .flush(abort),
    .d    ({issue, hcnt, wcnt}),
    .q    ({out_vld, out_haddr, out_waddr})
  );

  assign out_we_n = ~out_vld;

endmodule

// File: tb/tb_cnn_accel_sched.sv
// Scoreboard bench for cnn_accel_sched.
// Default 8x8x8 instance plus a 3x5 instance with longer latencies.
module tb_cnn_accel_sched;

  localparam int H  = 8;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int RL = 1;
  localparam int CL = 2;
  localparam int PL = RL + CL;
  localparam int H6 = 3;
  localparam int W6 = 5;
  localparam int P6 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start, abort, busy, done;
  logic        ld_req, ld_gnt;
  logic [3:0]  ld_sel;
  logic [2:0]  ld_haddr, ld_waddr;
  logic [31:0] ld_data;
  logic [8:0]  mem_rw;
  logic [2:0]  mem_haddr, mem_waddr;
  logic [31:0] mem_wdata;
  logic        comp_en, comp_sof, out_we_n;
  logic [2:0]  out_haddr, out_waddr;

  logic        start6, abort6, busy6, done6;
  logic        ld_req6, ld_gnt6;
  logic [3:0]  ld_sel6;
  logic [1:0]  ld_haddr6;
  logic [2:0]  ld_waddr6;
  logic [31:0] ld_data6;
  logic [8:0]  mem_rw6;
  logic [1:0]  mem_haddr6;
  logic [2:0]  mem_waddr6;
  logic [31:0] mem_wdata6;
  logic        comp_en6, comp_sof6, out_we_n6;
  logic [1:0]  out_haddr6;
  logic [2:0]  out_waddr6;

  cnn_accel_sched u_dut (
    .clk(clk), .reset(reset),
    .start(start), .abort(abort),
    .busy(busy), .done(done),
    .ld_req(ld_req), .ld_sel(ld_sel),
    .ld_haddr(ld_haddr), .ld_waddr(ld_waddr),
    .ld_data(ld_data), .ld_gnt(ld_gnt),
    .mem_rw(mem_rw), .mem_haddr(mem_haddr),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .comp_en(comp_en), .comp_sof(comp_sof),
    .out_we_n(out_we_n), .out_haddr(out_haddr),
    .out_waddr(out_waddr)
  );

  cnn_accel_sched #(
    .HEIGHT(H6), .WIDTH(W6), .RD_LAT(2), .COMP_LAT(3)
  ) u_dut6 (
    .clk(clk), .reset(reset),
    .start(start6), .abort(abort6),
    .busy(busy6), .done(done6),
    .ld_req(ld_req6), .ld_sel(ld_sel6),
    .ld_haddr(ld_haddr6), .ld_waddr(ld_waddr6),
    .ld_data(ld_data6), .ld_gnt(ld_gnt6),
    .mem_rw(mem_rw6), .mem_haddr(mem_haddr6),
    .mem_waddr(mem_waddr6), .mem_wdata(mem_wdata6),
    .comp_en(comp_en6), .comp_sof(comp_sof6),
    .out_we_n(out_we_n6), .out_haddr(out_haddr6),
    .out_waddr(out_waddr6)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [5:0] q [$];
  logic [4:0] q6 [$];

  int ce_cnt, ce_first, ce_last;
  int sof_cnt, sof_cyc, done_cnt, first_we;
  int we6_cnt, first_we6;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!out_we_n) begin
      check("out_addr", {1'b1, out_haddr, out_waddr},
            q.size() != 0 ? {1'b1, q.pop_front()} : 7'h0);
      if (first_we < 0) first_we = cyc;
    end
    if (comp_en) begin
      ce_cnt++;
      if (ce_first < 0) ce_first = cyc;
      ce_last = cyc;
    end
    if (comp_sof) begin
      sof_cnt++;
      sof_cyc = cyc;
    end
    if (done) done_cnt++;
  end

  always @(negedge clk) begin
    if (!out_we_n6) begin
      check("out6_addr", {1'b1, out_haddr6, out_waddr6},
            q6.size() != 0 ? {1'b1, q6.pop_front()} : 6'h0);
      we6_cnt++;
      if (first_we6 < 0) first_we6 = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    ce_cnt = 0; ce_first = -1; ce_last = -1;
    sof_cnt = 0; sof_cyc = -1;
    done_cnt = 0; first_we = -1;
    we6_cnt = 0; first_we6 = -1;
  endtask

  task automatic push_pass;
    for (int h = 0; h < H; h++)
      for (int w = 0; w < W; w++)
        q.push_back({3'(h), 3'(w)});
  endtask

  task automatic wait_done(input bit six, input int bound,
                           output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (six ? done6 : done) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic find_pix(input logic [2:0] h, input logic [2:0] w,
                          output bit found);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && mem_haddr == h && mem_waddr == w) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_gnt"}, ld_gnt, 0);
    check({tag, "_rw"}, mem_rw, 9'h1ff);
    check({tag, "_ha"}, mem_haddr, 0);
    check({tag, "_wa"}, mem_waddr, 0);
    check({tag, "_wd"}, mem_wdata, 0);
    check({tag, "_ce"}, comp_en, 0);
    check({tag, "_sof"}, comp_sof, 0);
    check({tag, "_we"}, out_we_n, 1);
    check({tag, "_oha"}, out_haddr, 0);
    check({tag, "_owa"}, out_waddr, 0);
  endtask

  task automatic full_pass(input string tag);
    int c0, at;
    clr_mon();
    start = 1;
    c0 = cyc;
    push_pass();
    tick();
    start = 0;
    check({tag, "_first_h"}, mem_haddr, 0);
    check({tag, "_first_w"}, mem_waddr, 0);
    wait_done(0, 200, at);
    check({tag, "_done_lat"}, at - c0, 64 + PL + 1);
    check({tag, "_ce_first"}, ce_first - c0, 1 + RL);
    check({tag, "_ce_cnt"}, ce_cnt, 64);
    check({tag, "_ce_span"}, ce_last - ce_first, 63);
    check({tag, "_sof_cnt"}, sof_cnt, 1);
    check({tag, "_sof_cyc"}, sof_cyc, ce_first);
    check({tag, "_we_first"}, first_we - c0, 1 + PL);
    check({tag, "_sb_left"}, q.size(), 0);
    tick();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_done1"}, done, 0);
  endtask

  initial begin
    logic [8:0] erw;
    int c0, at;
    bit found;

    reset = 1;
    start = 0; abort = 0; ld_req = 0;
    ld_sel = 0; ld_haddr = 0; ld_waddr = 0; ld_data = 0;
    start6 = 0; abort6 = 0; ld_req6 = 0;
    ld_sel6 = 0; ld_haddr6 = 0; ld_waddr6 = 0; ld_data6 = 0;
    clr_mon();
    repeat (3) @(posedge clk);
    #1;
    check_rst("rst");
    reset = 0;
    tick();

    for (int s = 0; s <= D + 1; s++) begin
      for (int h = 0; h < H; h++) begin
        for (int w = 0; w < W; w++) begin
          ld_req = 1;
          ld_sel = 4'(s);
          ld_haddr = 3'(h);
          ld_waddr = 3'(w);
          ld_data = $urandom;
          @(negedge clk);
          erw = '1;
          if (s <= D) erw[s] = 1'b0;
          check("ld_gnt", ld_gnt, 1);
          check("ld_rw", mem_rw, erw);
          if (s <= D) begin
            check("ld_ha", mem_haddr, h);
            check("ld_wa", mem_waddr, w);
            check("ld_wd", mem_wdata, ld_data);
          end else begin
            check("ld_drop_wd", mem_wdata, 0);
          end
          tick();
        end
      end
    end
    ld_req = 0;
    full_pass("p1");

    start = 1;
    ld_req = 1; ld_sel = 1; ld_haddr = 2; ld_waddr = 3;
    ld_data = 32'hcafe_0001;
    @(negedge clk);
    check("t3_gnt0", ld_gnt, 1);
    check("t3_rw0", mem_rw, 9'h1fd);
    tick();
    start = 0;
    ld_data = 32'hcafe_0002;
    @(negedge clk);
    check("t3_gnt1", ld_gnt, 1);
    check("t3_busy1", busy, 0);
    check("t3_wd1", mem_wdata, 32'hcafe_0002);
    tick();
    ld_req = 0;
    @(negedge clk);
    check("t3_busy2", busy, 0);
    clr_mon();
    c0 = cyc;
    push_pass();
    tick();
    check("t3_run", busy, 1);
    check("t3_h0", mem_haddr, 0);
    check("t3_w0", mem_waddr, 0);
    wait_done(0, 200, at);
    check("t3_done_lat", at - c0, 64 + PL + 1);
    tick();

    clr_mon();
    start = 1;
    c0 = cyc;
    push_pass();
    tick();
    start = 0;
    ld_req = 1; ld_sel = 2; ld_haddr = 1; ld_waddr = 1;
    ld_data = 32'h1234_5678;
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy || done) check("t4_stall", ld_gnt, 0);
      if (done) begin
        at = cyc;
        break;
      end
    end
    check("t4_done_lat", at - c0, 64 + PL + 1);
    tick();
    check("t4_gnt_after", ld_gnt, 1);
    check("t4_rw_after", mem_rw, 9'h1fb);
    ld_req = 0;
    tick();

    clr_mon();
    start = 1;
    push_pass();
    tick();
    start = 0;
    find_pix(3'd2, 3'd0, found);
    check("t5_found", found, 1);
    abort = 1;
    tick();
    abort = 0;
    check("t5_busy", busy, 0);
    check("t5_we", out_we_n, 1);
    @(negedge clk);
    #1;
    check("t5_sb_left", q.size(), 50);
    q.delete();
    repeat (12) @(negedge clk);
    check("t5_no_done", done_cnt, 0);
    check("t5_idle", busy, 0);
    tick();
    start = 1;
    abort = 1;
    tick();
    start = 0;
    abort = 0;
    check("t5_sa_busy", busy, 0);
    tick();
    check("t5_sa_pend", busy, 0);

    clr_mon();
    start = 1;
    push_pass();
    tick();
    start = 0;
    find_pix(3'd3, 3'd5, found);
    check("t1_found", found, 1);
    #1;
    reset = 1;
    tick();
    check_rst("t1");
    check("t1_sb_left", q.size(), 37);
    q.delete();
    reset = 0;
    tick();
    full_pass("t1p");

    clr_mon();
    start6 = 1;
    c0 = cyc;
    for (int h = 0; h < H6; h++)
      for (int w = 0; w < W6; w++)
        q6.push_back({2'(h), 3'(w)});
    tick();
    start6 = 0;
    wait_done(1, 200, at);
    check("t6_done_lat", at - c0, H6 * W6 + P6 + 1);
    check("t6_we_cnt", we6_cnt, H6 * W6);
    check("t6_we_first", first_we6 - (c0 + 1), P6);
    check("t6_sb_left", q6.size(), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
